ripple_carry_adder_32bit: RTL and testbench
===========================================

// Module: ripple_carry_adder_32bit
//
// PURPOSE
// - 32-bit unsigned adder: in1 + in2 + c_in -> {c_out, sum}, carry chain built as 32 cascaded full adders (ripple).
// - Result captured in an output register, so the block is a single-stage, clocked datapath element.
// - Sits in the ALU/datapath as the baseline adder; faster adders (CLA etc.) are compared against it.
//
// PARAMETERS
// - WIDTH  32  operand/sum width; ripple chain length = WIDTH full adders (only 32 is required/verified)
//
// PORTS
// - clk    in   1      rising-edge clock; only clock
// - rst    in   1      synchronous, active-high reset
// - in1    in   32     operand A, unsigned
// - in2    in   32     operand B, unsigned
// - c_in   in   1      carry into bit 0
// - sum    out  32     registered sum bits [31:0]
// - c_out  out  1      registered carry out of bit 31
//
// BEHAVIOUR
// - One clock; reset is synchronous and active-high (clk, rst).
// - Full adder per bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = c_in.
// - Carry ripples strictly bit 0 -> bit 31; no lookahead/select logic. Chain is purely combinational.
// - {c_out, sum} = in1 + in2 + c_in, exact 33-bit result; no truncation other than c_out holding bit 32.
// - Register stage: on each rising clk, if rst=1 then sum<=0, c_out<=0; else sum<=s, c_out<=c[32].
// - Reset values: sum=32'h0, c_out=0. rst has priority over new operands in the same cycle.
// - Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
//   Throughput: one new operation every cycle; no handshake, no valid signals.
// - Outputs before the first clock edge (no reset applied) are X; bench must reset first.
// - Reset asserted mid-stream: the next edge clears the outputs; the in-flight result is discarded.
//   First post-reset result appears one edge after rst deasserts.
// - Wrap-around: unsigned overflow sets c_out=1; sum holds the low 32 bits (mod 2^32).
// - Signed overflow is not flagged (caller derives it from operand MSBs if needed).
// - Worst-case path: in1/in2 bit 0 or c_in -> c[32]/sum[31] through 32 carry stages; the clock
//   period must cover this (target <= 100 ns in simulation).
// - No latches; all outputs driven from flops; combinational chain has no feedback.
//
// TESTING
// - Reset: rst=1 for 2 edges with any operands -> sum=0, c_out=0; deassert, next edge shows the live result.
// - 12345678 + 98765432, c_in=0 -> sum=111111110, c_out=0; with c_in=1 -> sum=111111111, c_out=0.
// - 4294967290 + 5, c_in=0 -> sum=4294967295, c_out=0 (max value, no carry).
// - 4294967290 + 6, c_in=0 -> sum=0, c_out=1; 4294967290 + 6, c_in=1 -> sum=1, c_out=1.
// - Full ripple: 32'hFFFFFFFF + 0, c_in=1 -> sum=0, c_out=1; 32'hFFFFFFFF + 32'hFFFFFFFF, c_in=1
//   -> sum=32'hFFFFFFFF, c_out=1.
// - Back-to-back: new operands every cycle, random 10k vectors -> each result equals the 33-bit
//   reference sum exactly 1 cycle later; assert rst once mid-stream -> zeros for that cycle.

Source files
------------

// File: rtl/ripple_carry_adder_32bit.sv
// 32-bit ripple-carry adder with a registered {c_out, sum} result.
// Baseline datapath adder: the carry walks bit 0 -> bit WIDTH-1 through cascaded full adders.
module ripple_carry_adder_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // One full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic p;
    p = a ^ b;
    return {(a & b) | (c & p), p ^ c};
  endfunction

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;

  assign carry_s[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign {carry_s[i+1], sum_s[i]} = full_add(in1[i], in2[i], carry_s[i]);
  end

  // Output register; reset wins over the operands presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= {WIDTH{1'b0}};
      c_out <= 1'b0;
    end else begin
      sum   <= sum_s;
      c_out <= carry_s[WIDTH];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_32bit.sv
// Directed and back-to-back random checks of ripple_carry_adder_32bit.
// Inputs change on the falling edge; outputs are sampled on the falling edge after capture.
module tb_ripple_carry_adder_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        c_in;
  logic [31:0] sum;
  logic        c_out;

  int err_cnt;
  int chk_cnt;

  ripple_carry_adder_32bit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .in1   (in1),
    .in2   (in2),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [32:0] observed, input logic [32:0] expected);
    chk_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("FAIL %s: got c_out=%b sum=%h, expected c_out=%b sum=%h",
               tag, observed[32], observed[31:0], expected[32], expected[31:0]);
    end
  endtask

  // Present one operand set, let one rising edge capture it, then sample.
  task automatic apply_and_check(input string tag, input logic r, input logic [31:0] a,
                                 input logic [31:0] b, input logic c, input logic [32:0] expected);
    @(negedge clk);
    rst  = r;
    in1  = a;
    in2  = b;
    c_in = c;
    @(negedge clk);
    check_value(tag, {c_out, sum}, expected);
  endtask

  logic [32:0] exp_prev;
  logic        have_prev;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rc;

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    rst  = 1'b1;
    in1  = 32'hDEAD_BEEF;
    in2  = 32'h1234_5678;
    c_in = 1'b1;

    apply_and_check("reset_edge1", 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 33'h0);
    apply_and_check("reset_edge2", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h0);
    apply_and_check("post_reset",  1'b0, 32'd1, 32'd2, 1'b0, {1'b0, 32'd3});

    apply_and_check("dec_cin0",    1'b0, 32'd12345678, 32'd98765432, 1'b0, {1'b0, 32'd111111110});
    apply_and_check("dec_cin1",    1'b0, 32'd12345678, 32'd98765432, 1'b1, {1'b0, 32'd111111111});
    apply_and_check("max_nocarry", 1'b0, 32'd4294967290, 32'd5, 1'b0, {1'b0, 32'd4294967295});
    apply_and_check("wrap_cin0",   1'b0, 32'd4294967290, 32'd6, 1'b0, {1'b1, 32'd0});
    apply_and_check("wrap_cin1",   1'b0, 32'd4294967290, 32'd6, 1'b1, {1'b1, 32'd1});
    apply_and_check("ripple_ff_0", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, {1'b1, 32'h0});
    apply_and_check("ripple_ff_ff",1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'hFFFF_FFFF});
    apply_and_check("alt_bits",    1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, {1'b0, 32'hFFFF_FFFF});
    apply_and_check("alt_bits_c",  1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, {1'b1, 32'h0});
    apply_and_check("zero_zero",   1'b0, 32'h0, 32'h0, 1'b0, 33'h0);
    apply_and_check("msb_msb",     1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 32'h0});
    apply_and_check("rst_priority",1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 33'h0);

    // Back-to-back stream: each falling edge checks the previous operands and drives new ones.
    have_prev = 1'b0;
    exp_prev  = 33'h0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (have_prev) check_value("stream", {c_out, sum}, exp_prev);
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(1, 0));
      rst  = (i == 5000) ? 1'b1 : 1'b0;
      in1  = ra;
      in2  = rb;
      c_in = rc;
      exp_prev  = rst ? 33'h0 : ({1'b0, ra} + {1'b0, rb} + {32'h0, rc});
      have_prev = 1'b1;
    end
    @(negedge clk);
    check_value("stream_last", {c_out, sum}, exp_prev);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
